// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the 16x oversampled UART receiver.
// Optional parity support is selected with UART_RX_PARITY_EN.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DEF_OS_RATE   = 16;
   localparam int DEF_DATA_BITS = 8;
   localparam int DEF_CNT_WIDTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// RST_VAL sets the idle level the sync chain resets to.
`timescale 1ns/1ps
module sync_rise_det #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic r_rise;

   // sync chain plus one delay stage; the pulse is registered so it
   // lands three clocks after the pin edge
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_s1   <= RST_VAL;
         r_s2   <= RST_VAL;
         r_s3   <= RST_VAL;
         r_rise <= 1'b0;
      end else begin
         r_s1   <= d;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_rise <= r_s2 & ~r_s3;
      end
   end

   assign q    = r_s2;
   assign rise = r_rise;

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver clocked by a 16x oversample tick, mid-bit sampling.
// Define UART_RX_PARITY_EN to expect an even parity bit (adds parity_err).
`timescale 1ns/1ps
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int OS_RATE   = DEF_OS_RATE,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 os_clk_in,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
`ifdef UART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_WIDTH-1:0] C_HALF = CNT_WIDTH'(OS_RATE/2 - 1);
   localparam logic [CNT_WIDTH-1:0] C_FULL = CNT_WIDTH'(OS_RATE - 1);
   localparam logic [IDX_W-1:0]     C_LAST = IDX_W'(DATA_BITS - 1);

   logic                 w_os_tick;
   logic                 w_rxd_s;
   logic                 w_unused_os_lvl;
   logic                 w_unused_rxd_rise;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_deliver;
   logic                 w_ferr;
   logic                 r_deliver;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_rx_valid;
   logic [DATA_BITS-1:0] r_rx_data;
`ifdef UART_RX_PARITY_EN
   logic                 w_perr;
   logic                 r_parity_err;
   logic                 r_parbad;
   logic                 w_parbad_nxt;
`endif

   sync_rise_det #(.RST_VAL(1'b0)) u_os_sync (
      .clock (clock),
      .rst   (rst),
      .d     (os_clk_in),
      .q     (w_unused_os_lvl),
      .rise  (w_os_tick)
   );

   sync_rise_det #(.RST_VAL(1'b1)) u_rxd_sync (
      .clock (clock),
      .rst   (rst),
      .d     (rxd),
      .q     (w_rxd_s),
      .rise  (w_unused_rxd_rise)
   );

   // frame FSM: next state, tick counter, bit index and shift register
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_perr       = 1'b0;
      w_parbad_nxt = r_parbad;
`endif
      if (w_os_tick) begin
         unique case (r_state)
            ST_IDLE: begin
               if (!w_rxd_s) begin
                  w_state_nxt = ST_START;
                  w_cnt_nxt   = '0;
`ifdef UART_RX_PARITY_EN
                  w_parbad_nxt = 1'b0;
`endif
               end
            end
            ST_START: begin
               if (r_cnt == C_HALF) begin
                  if (w_rxd_s) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_state_nxt = ST_DATA;
                     w_cnt_nxt   = '0;
                     w_idx_nxt   = '0;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (r_cnt == C_FULL) begin
                  w_cnt_nxt   = '0;
                  w_shift_nxt = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                  w_idx_nxt   = r_idx + 1'b1;
                  if (r_idx == C_LAST) begin
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = ST_PARITY;
`else
                     w_state_nxt = ST_STOP;
`endif
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (r_cnt == C_FULL) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = ST_STOP;
                  if (w_rxd_s != ^r_shift) begin
                     w_perr       = 1'b1;
                     w_parbad_nxt = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (r_cnt == C_FULL) begin
                  w_cnt_nxt = '0;
                  if (w_rxd_s) begin
                     w_state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                     w_deliver   = ~r_parbad;
`else
                     w_deliver   = 1'b1;
`endif
                  end else begin
                     w_state_nxt = ST_BREAK;
                     w_ferr      = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_BREAK: begin
               if (w_rxd_s) begin
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_deliver   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_idx       <= w_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_deliver   <= w_deliver;
         r_frame_err <= w_ferr;
      end
   end

`ifdef UART_RX_PARITY_EN
   // parity error pulse and per-frame discard flag
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_parity_err <= 1'b0;
         r_parbad     <= 1'b0;
      end else begin
         r_parity_err <= w_perr;
         r_parbad     <= w_parbad_nxt;
      end
   end

   assign parity_err = r_parity_err;
`endif

   // output holding register with valid/ready handshake and overrun
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_deliver) begin
            if (!r_rx_valid || rx_ready) begin
               r_rx_data  <= r_shift;
               r_rx_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of single frames plus
// hand-written sequences for back-to-back, break, glitch, overrun, reset.
`timescale 1ns/1ps
module tb_uart_rx_os16;

   localparam int BIT = 640;

   logic       clock;
   logic       rst;
   logic       os_clk_in;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   int         perr_cnt = 0;
`endif

   int         n_chk  = 0;
   int         n_fail = 0;
   int         hs_cnt = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   logic [7:0] last_hs = 8'h00;
   logic [7:0] hs_q[$];

   uart_rx_os16 dut (
      .clock     (clock),
      .rst       (rst),
      .os_clk_in (os_clk_in),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
`ifdef UART_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      os_clk_in = 1'b0;
      forever #20 os_clk_in = ~os_clk_in;
   end

   always @(negedge clock) begin
      if (rx_valid && rx_ready) begin
         hs_cnt++;
         last_hs = rx_data;
         hs_q.push_back(rx_data);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      rxd = 1'b0;
      #(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         #(BIT);
      end
`ifdef UART_RX_PARITY_EN
      rxd = ^d;
      #(BIT);
`endif
      rxd = stop_v;
      #(BIT);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_bad_par(input logic [7:0] d);
      rxd = 1'b0;
      #(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         #(BIT);
      end
      rxd = ~(^d);
      #(BIT);
      rxd = 1'b1;
      #(BIT);
   endtask
`endif

   typedef struct {
      logic [7:0] d;
      logic       stop_v;
      int         exp_hs;
      int         exp_fe;
   } vec_t;

   vec_t vt[6];

   int b_hs, b_fe, b_ov, b_q;

   initial begin
      vt[0] = '{8'h55, 1'b1, 1, 0};
      vt[1] = '{8'h01, 1'b1, 1, 0};
      vt[2] = '{8'h80, 1'b1, 1, 0};
      vt[3] = '{8'hC3, 1'b1, 1, 0};
      vt[4] = '{8'h5A, 1'b0, 0, 1};
      vt[5] = '{8'hE7, 1'b1, 1, 0};

      rst      = 1'b0;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      @(posedge clock); #1;
      rst      = 1'b1;
      rx_ready = 1'b1;
      #(2*BIT);

      for (int i = 0; i < 6; i++) begin
         b_hs = hs_cnt;
         b_fe = fe_cnt;
         send_frame(vt[i].d, vt[i].stop_v);
         rxd = 1'b1;
         #(3*BIT);
         @(negedge clock);
         chk("tbl_hs", hs_cnt - b_hs, vt[i].exp_hs);
         chk("tbl_ferr", fe_cnt - b_fe, vt[i].exp_fe);
         if (vt[i].exp_hs > 0) chk("tbl_data", last_hs, vt[i].d);
         else chk("tbl_novalid", rx_valid, 0);
      end

      b_q  = hs_q.size();
      b_fe = fe_cnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      #(3*BIT);
      @(negedge clock);
      chk("b2b_count", hs_q.size() - b_q, 2);
      if (hs_q.size() - b_q == 2) begin
         chk("b2b_first", hs_q[b_q], 8'h00);
         chk("b2b_second", hs_q[b_q+1], 8'hFF);
      end
      chk("b2b_ferr", fe_cnt - b_fe, 0);

      b_hs = hs_cnt;
      b_fe = fe_cnt;
      send_frame(8'hA5, 1'b0);
      #(11*BIT);
      @(negedge clock);
      chk("brk_ferr", fe_cnt - b_fe, 1);
      chk("brk_hs", hs_cnt - b_hs, 0);
      chk("brk_valid", rx_valid, 0);
      rxd = 1'b1;
      #(2*BIT);
      send_frame(8'h96, 1'b1);
      #(2*BIT);
      chk("brk_recov_hs", hs_cnt - b_hs, 1);
      chk("brk_recov_data", last_hs, 8'h96);
      chk("brk_recov_ferr", fe_cnt - b_fe, 1);

      b_hs = hs_cnt;
      b_fe = fe_cnt;
      rxd = 1'b0;
      #160;
      rxd = 1'b1;
      #(12*BIT);
      chk("glitch_hs", hs_cnt - b_hs, 0);
      chk("glitch_ferr", fe_cnt - b_fe, 0);

      @(posedge clock); #1;
      rx_ready = 1'b0;
      b_hs = hs_cnt;
      b_ov = ov_cnt;
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      #(2*BIT);
      @(negedge clock);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h12);
      chk("ovr_pulse", ov_cnt - b_ov, 1);
      chk("ovr_nohs", hs_cnt - b_hs, 0);
      @(posedge clock); #1;
      rx_ready = 1'b1;
      @(posedge clock); #1;
      rx_ready = 1'b0;
      @(negedge clock);
      chk("acc_hs", hs_cnt - b_hs, 1);
      chk("acc_data", last_hs, 8'h12);
      chk("acc_valid", rx_valid, 0);
      chk("acc_hold", rx_data, 8'h12);

      @(posedge clock); #1;
      rx_ready = 1'b1;
      rxd = 1'b0;
      #(BIT);
      rxd = 1'b1;
      #(BIT);
      rxd = 1'b0;
      #(2*BIT);
      @(posedge clock); #1;
      rst = 1'b0;
      rxd = 1'b1;
      @(posedge clock); #1;
      chk("mrst_valid", rx_valid, 0);
      chk("mrst_data", rx_data, 0);
      chk("mrst_ferr", frame_err, 0);
      chk("mrst_ovr", overrun, 0);
      rst = 1'b1;
      b_hs = hs_cnt;
      b_fe = fe_cnt;
      #(12*BIT);
      send_frame(8'h3C, 1'b1);
      #(2*BIT);
      chk("mrst_hs", hs_cnt - b_hs, 1);
      chk("mrst_rx", last_hs, 8'h3C);
      chk("mrst_noferr", fe_cnt - b_fe, 0);

`ifdef UART_RX_PARITY_EN
      b_hs = hs_cnt;
      b_fe = fe_cnt;
      begin
         int b_pe;
         b_pe = perr_cnt;
         send_bad_par(8'h07);
         #(2*BIT);
         chk("par_err", perr_cnt - b_pe, 1);
         chk("par_hs", hs_cnt - b_hs, 0);
         chk("par_ferr", fe_cnt - b_fe, 0);
         send_frame(8'h07, 1'b1);
         #(2*BIT);
         chk("par_good_hs", hs_cnt - b_hs, 1);
         chk("par_good_data", last_hs, 8'h07);
         chk("par_good_err", perr_cnt - b_pe, 1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
